shared_resource_arbiter: RTL and testbench

//  - Responder end of the pipeline-to-shared-resource interface. Arbitrates
//    N_REQ pipeline requesters onto one multi-cycle compute resource.
//  - Grants one requester, captures its operand and returns the result to it
//    on a one-hot valid. Sits between the last stage of each pipeline and the

---
 rtl/shared_resource_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_shared_resource_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_resource_arbiter.sv
// Arbitrates N_REQ pipeline requesters onto one multi-cycle multiplier and returns the result.
// Macro ARB_ROUND_ROBIN_EN: round-robin selection from rr_ptr; undefined gives fixed priority.
module shared_resource_arbiter #(
    parameter int N_REQ   = 2,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 3,
    parameter int TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic                    busy
);
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HALF_W = DATA_W / 2;
    localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t             state_reg,     state_next;
    logic [IDX_W-1:0]   winner_reg,    winner_next;
    logic [TMR_W-1:0]   timer_reg,     timer_next;
    logic [LAT_W-1:0]   lat_cnt_reg,   lat_cnt_next;
    logic [DATA_W-1:0]  op_reg,        op_next;
    logic [N_REQ-1:0]   grant_reg,     grant_next;
    logic [N_REQ-1:0]   rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]  rsp_data_reg,  rsp_data_next;
    logic               busy_reg,      busy_next;
`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   rr_ptr_reg,    rr_ptr_next;
`endif

    logic [DATA_W-1:0]  req_slice [N_REQ];
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [HALF_W-1:0]  op_hi;
    logic [HALF_W-1:0]  op_lo;
    logic [DATA_W-1:0]  product;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign req_slice[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int ofs);
        int sum;
        sum = base + ofs;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return IDX_W'(sum);
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction
`endif

    // Winner selection: scan starts at rr_ptr (round-robin) or at index 0 (fixed priority).
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (!pick_found && req[wrap_idx(int'(rr_ptr_reg), k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_idx(int'(rr_ptr_reg), k);
            end
`else
            if (!pick_found && req[k]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(k);
            end
`endif
        end
    end

    // The operand packs two half-width factors; the full-width product cannot overflow.
    assign op_hi   = op_reg[DATA_W-1:HALF_W];
    assign op_lo   = op_reg[HALF_W-1:0];
    assign product = DATA_W'(op_hi) * DATA_W'(op_lo);

    always_comb begin
        state_next     = state_reg;
        winner_next    = winner_reg;
        timer_next     = timer_reg;
        lat_cnt_next   = lat_cnt_reg;
        op_next        = op_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_valid_next = '0;
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr_next    = rr_ptr_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    state_next  = ST_GRANT;
                    winner_next = pick_idx;
                    timer_next  = '0;
                end
            end
            ST_GRANT: begin
                if (req_valid[winner_reg]) begin
                    op_next      = req_slice[winner_reg];
                    lat_cnt_next = LAT_LOAD;
                    state_next   = (LATENCY > 1) ? ST_BUSY : ST_RESP;
                end else if (!req[winner_reg]) begin
                    // Withdrawn request: the pointer stays so the same requester keeps its turn.
                    state_next = ST_IDLE;
                end else if (timer_reg == TMR_LAST) begin
                    state_next = ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_ptr_next = next_idx(winner_reg);
`endif
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            ST_BUSY: begin
                if (lat_cnt_reg == '0) begin
                    state_next = ST_RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg - 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid_next = onehot(winner_reg);
                rsp_data_next  = product;
                state_next     = ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                rr_ptr_next    = next_idx(winner_reg);
`endif
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of the decoded next state.
        grant_next = (state_next == ST_GRANT) ? onehot(winner_next) : '0;
        busy_next  = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            winner_reg    <= '0;
            timer_reg     <= '0;
            lat_cnt_reg   <= '0;
            op_reg        <= '0;
            grant_reg     <= '0;
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            busy_reg      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_reg    <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            winner_reg    <= winner_next;
            timer_reg     <= timer_next;
            lat_cnt_reg   <= lat_cnt_next;
            op_reg        <= op_next;
            grant_reg     <= grant_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            busy_reg      <= busy_next;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_reg    <= rr_ptr_next;
`endif
        end
    end

    assign grant     = grant_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Directed and randomized checks of shared_resource_arbiter against a transaction-level model.
// The model follows ARB_ROUND_ROBIN_EN the same way the design does.
`timescale 1ns/1ps
module tb_shared_resource_arbiter;
    localparam int N_REQ   = 2;
    localparam int DATA_W  = 32;
    localparam int LATENCY = 3;
    localparam int TIMEOUT = 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ*DATA_W-1:0] req_data = '0;
    logic [N_REQ-1:0]        grant;
    logic [DATA_W-1:0]       rsp_data;
    logic [N_REQ-1:0]        rsp_valid;
    logic                    busy;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int model_ptr  = 0;
    bit mon_en     = 1'b0;
    logic [DATA_W-1:0] op_arr [N_REQ];

    shared_resource_arbiter #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .LATENCY(LATENCY),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_valid(req_valid),
        .req_data (req_data),
        .grant    (grant),
        .rsp_data (rsp_data),
        .rsp_valid(rsp_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Winner = first requesting index at or after the pointer, scanning with wrap.
    function automatic int model_winner(input logic [N_REQ-1:0] mask);
        int start;
        start = RR_MODE ? model_ptr : 0;
        for (int k = 0; k < N_REQ; k++) begin
            if (mask[(start + k) % N_REQ]) return (start + k) % N_REQ;
        end
        return 0;
    endfunction

    function automatic logic [DATA_W-1:0] model_product(input logic [DATA_W-1:0] op);
        longint unsigned hi, lo;
        hi = longint'(op) >> (DATA_W / 2);
        lo = longint'(op) % (longint'(1) << (DATA_W / 2));
        return DATA_W'(hi * lo);
    endfunction

    task automatic load_operands();
        for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = op_arr[i];
    endtask

    // One full transaction: request, optional wait in GRANT, capture, response.
    task automatic run_txn(input logic [N_REQ-1:0] mask, input int delay, input bit stray);
        int w;
        logic [N_REQ-1:0]  w_oh;
        logic [DATA_W-1:0] exp_data;
        w        = model_winner(mask);
        w_oh     = '0;
        w_oh[w]  = 1'b1;
        exp_data = model_product(op_arr[w]);
        load_operands();
        req = mask;
        step();
        check("grant", DATA_W'(grant), DATA_W'(w_oh));
        check("rsp_valid_in_grant", DATA_W'(rsp_valid), '0);
        check("busy_in_grant", DATA_W'(busy), DATA_W'(1));
        for (int d = 0; d < delay; d++) begin
            req_valid = stray ? ~w_oh : '0;
            step();
            check("grant_hold", DATA_W'(grant), DATA_W'(w_oh));
        end
        req_valid = w_oh;
        step();
        req_valid = '0;
        check("grant_drop_after_capture", DATA_W'(grant), '0);
        for (int c = 1; c <= LATENCY; c++) begin
            step();
            if (c < LATENCY) begin
                check("rsp_valid_early", DATA_W'(rsp_valid), '0);
                check("busy_in_flight", DATA_W'(busy), DATA_W'(1));
            end
        end
        check("rsp_valid", DATA_W'(rsp_valid), DATA_W'(w_oh));
        check("rsp_data", rsp_data, exp_data);
        check("busy_after_resp", DATA_W'(busy), '0);
        $display("txn req=%b winner=%0d op=%h rsp=%h", mask, w, op_arr[w], rsp_data);
        model_ptr = (w + 1) % N_REQ;
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            check("grant_onehot0", DATA_W'($onehot0(grant)), DATA_W'(1));
            check("rsp_valid_onehot0", DATA_W'($onehot0(rsp_valid)), DATA_W'(1));
            check("grant_rsp_exclusive", DATA_W'((|grant) && (|rsp_valid)), '0);
        end
    end

    initial begin
        int w;
        logic [N_REQ-1:0] w_oh;
        logic [N_REQ-1:0] m;
        for (int i = 0; i < N_REQ; i++) op_arr[i] = '0;

        // Reset state
        #2 reset = 1'b1;
        step();
        step();
        check("reset_grant", DATA_W'(grant), '0);
        check("reset_rsp_valid", DATA_W'(rsp_valid), '0);
        check("reset_rsp_data", rsp_data, '0);
        check("reset_busy", DATA_W'(busy), '0);
        reset = 1'b0;
        mon_en = 1'b1;
        model_ptr = 0;
        step();

        // Basic transaction
        op_arr[0] = 32'h0003_0005;
        op_arr[1] = 32'h0000_0000;
        run_txn(2'b01, 0, 1'b0);
        check("basic_product", rsp_data, 32'h0000_000F);

        // Both requesting, held
        op_arr[0] = 32'h0002_0007;
        op_arr[1] = 32'h0004_0009;
        for (int t = 0; t < 3; t++) run_txn(2'b11, 0, 1'b0);

        // Timeout with req held and no req_valid
        w = model_winner(2'b11);
        w_oh = '0;
        w_oh[w] = 1'b1;
        req = 2'b11;
        step();
        check("timeout_grant", DATA_W'(grant), DATA_W'(w_oh));
        for (int c = 1; c <= TIMEOUT; c++) begin
            step();
            if (c < TIMEOUT) begin
                check("timeout_grant_hold", DATA_W'(grant), DATA_W'(w_oh));
            end else begin
                check("timeout_grant_revoked", DATA_W'(grant), '0);
                check("timeout_busy", DATA_W'(busy), '0);
            end
        end
        $display("timeout winner=%0d grant=%b busy=%b", w, grant, busy);
        model_ptr = (w + 1) % N_REQ;
        run_txn(2'b10, 0, 1'b0);

        // Withdrawal during GRANT
        req = '0;
        step();
        w = model_winner(2'b01);
        w_oh = '0;
        w_oh[w] = 1'b1;
        req = 2'b01;
        step();
        check("withdraw_grant", DATA_W'(grant), DATA_W'(w_oh));
        req = '0;
        step();
        check("withdraw_grant_drop", DATA_W'(grant), '0);
        check("withdraw_busy", DATA_W'(busy), '0);
        for (int c = 0; c < LATENCY + 2; c++) begin
            step();
            check("withdraw_no_rsp", DATA_W'(rsp_valid), '0);
        end
        $display("withdraw grant=%b rsp_valid=%b", grant, rsp_valid);

        // Max operand, stray req_valid from the non-granted requester
        op_arr[0] = 32'hFFFF_FFFF;
        op_arr[1] = 32'h1234_5678;
        run_txn(2'b01, 1, 1'b1);
        check("max_product", rsp_data, 32'hFFFE_0001);

        // Reset while BUSY
        req = '0;
        step();
        op_arr[0] = 32'h0011_0022;
        load_operands();
        req = 2'b01;
        step();
        check("rst_busy_grant", DATA_W'(grant), DATA_W'(1));
        req_valid = 2'b01;
        step();
        req_valid = '0;
        req = '0;
        check("rst_busy_pre", DATA_W'(busy), DATA_W'(1));
        #2 reset = 1'b1;
        #1;
        check("rst_async_grant", DATA_W'(grant), '0);
        check("rst_async_rsp_valid", DATA_W'(rsp_valid), '0);
        check("rst_async_busy", DATA_W'(busy), '0);
        check("rst_async_rsp_data", rsp_data, '0);
        step();
        reset = 1'b0;
        model_ptr = 0;
        for (int c = 0; c < LATENCY + 2; c++) begin
            step();
            check("rst_no_rsp", DATA_W'(rsp_valid), '0);
            check("rst_idle_busy", DATA_W'(busy), '0);
        end
        $display("reset in busy: grant=%b rsp_valid=%b busy=%b", grant, rsp_valid, busy);
        run_txn(2'b01, 0, 1'b0);

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            for (int i = 0; i < N_REQ; i++) op_arr[i] = $urandom;
            run_txn(m, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                req = '0;
                step();
                check("gap_idle_grant", DATA_W'(grant), '0);
                check("gap_idle_busy", DATA_W'(busy), '0);
            end
        end

        req = '0;
        step();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
